// File: rtl/addsub_result_buffer_if.sv
// Stream bundle between the add/sub result buffer and its producer/consumer.
// The slave side is the buffer; the master side drives capture inputs and out_ready.
interface addsub_result_buffer_if #(
  parameter int DATA_WIDTH = 4,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = 8
);
  logic                     in_en;
  logic                     in_ctrl;
  logic [DATA_WIDTH:0]      in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [DATA_WIDTH:0]      out_data;
  logic                     out_op;
  logic                     out_flag;
  logic                     full;
  logic                     empty;
  logic [$clog2(DEPTH):0]   level;
  logic [CNT_WIDTH-1:0]     drop_cnt;

  modport master (
    output in_en, in_ctrl, in_data, out_ready,
    input  out_valid, out_data, out_op, out_flag, full, empty, level, drop_cnt
  );

  modport slave (
    input  in_en, in_ctrl, in_data, out_ready,
    output out_valid, out_data, out_op, out_flag, full, empty, level, drop_cnt
  );
endinterface

// File: rtl/addsub_result_buffer.sv
// Captures the registered add/sub result one cycle after each enable, tags it with
// its op, and queues it in a show-ahead FIFO with a saturating overflow counter.
module addsub_result_buffer #(
  parameter int DATA_WIDTH = 4,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  addsub_result_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int DW = DATA_WIDTH + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  typedef struct packed {
    logic          op;
    logic [DW-1:0] data;
  } entry_t;

  entry_t                mem [DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [LW-1:0]         lvl;
  logic                  pend, pend_op;
  logic [CNT_WIDTH-1:0]  drops;

  logic is_full, is_empty, do_pop, do_push, drop;
  entry_t head;

  assign is_full  = (lvl == FULL_LVL);
  assign is_empty = (lvl == '0);
  assign do_pop   = !is_empty && bus.out_ready;
  // A pop on the same edge frees the slot, so a full FIFO still accepts.
  assign do_push  = pend && (!is_full || do_pop);
  assign drop     = pend && is_full && !do_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend    <= 1'b0;
      pend_op <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      lvl     <= '0;
      drops   <= '0;
    end else begin
      pend    <= bus.in_en;
      pend_op <= bus.in_ctrl;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      lvl <= lvl + 1'b1;
      else if (!do_push && do_pop) lvl <= lvl - 1'b1;
      if (drop && drops != '1) drops <= drops + 1'b1;
    end
  end

  // Storage needs no reset; the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= '{op: pend_op, data: bus.in_data};
  end

  assign head          = mem[rd_ptr];
  assign bus.out_valid = !is_empty;
  assign bus.out_data  = is_empty ? '0 : head.data;
  assign bus.out_op    = is_empty ? 1'b0 : head.op;
  assign bus.out_flag  = is_empty ? 1'b0 : head.data[DW-1];
  assign bus.full      = is_full;
  assign bus.empty     = is_empty;
  assign bus.level     = lvl;
  assign bus.drop_cnt  = drops;
endmodule

// File: tb/tb_addsub_result_buffer.sv
// Randomized + directed bench: queue-based reference model with a negedge monitor.
module tb_addsub_result_buffer;
  localparam int DW = 5;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  addsub_result_buffer_if #(.DATA_WIDTH(4), .DEPTH(4), .CNT_WIDTH(8)) b ();
  addsub_result_buffer #(.DATA_WIDTH(4), .DEPTH(4), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(b)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: expected FIFO contents as {op, data}.
  logic [DW:0] m_q[$];
  logic        m_pend = 1'b0;
  logic        m_pend_op = 1'b0;
  int          m_drops = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic cyc(input bit en, input bit ctrl, input logic [DW-1:0] d, input bit rdy);
    @(posedge clk); #1;
    b.in_en = en; b.in_ctrl = ctrl; b.in_data = d; b.out_ready = rdy;
  endtask

  function automatic logic [DW-1:0] rnd_d();
    return DW'($urandom_range(0, 31));
  endfunction

  // Model update on each active edge, straight from the buffering rules.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_q.delete(); m_pend = 1'b0; m_pend_op = 1'b0; m_drops = 0;
    end else begin
      bit pop;
      pop = (m_q.size() != 0) && b.out_ready;
      if (pop) void'(m_q.pop_front());
      if (m_pend) begin
        if (m_q.size() < DEPTH) m_q.push_back({m_pend_op, b.in_data});
        else if (m_drops < 255) m_drops++;
      end
      m_pend = b.in_en;
      m_pend_op = b.in_ctrl;
    end
  end

  // Monitor: compares DUT state and head against the model away from the edge.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      chk("mon_valid", 32'(b.out_valid), 32'(m_q.size() != 0));
      chk("mon_level", 32'(b.level), 32'(m_q.size()));
      chk("mon_full", 32'(b.full), 32'(m_q.size() == DEPTH));
      chk("mon_empty", 32'(b.empty), 32'(m_q.size() == 0));
      chk("mon_drop", 32'(b.drop_cnt), 32'(m_drops));
      if (b.out_valid && m_q.size() != 0) begin
        chk("mon_head", 32'({b.out_op, b.out_data}), 32'(m_q[0]));
        chk("mon_flag", 32'(b.out_flag), 32'(m_q[0][DW-1]));
      end
    end
  end

  initial begin
    b.in_en = 1'b0; b.in_ctrl = 1'b0; b.in_data = '0; b.out_ready = 1'b0;

    // Reset held
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(b.out_valid), 0);
    chk("rst_empty", 32'(b.empty), 1);
    chk("rst_full", 32'(b.full), 0);
    chk("rst_level", 32'(b.level), 0);
    chk("rst_drop", 32'(b.drop_cnt), 0);
    chk("rst_data", 32'(b.out_data), 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Add result 7+5
    cyc(1, 1, '0, 0);
    cyc(0, 0, 5'b01100, 0);
    cyc(0, 0, '0, 0);
    @(negedge clk);
    chk("add_valid", 32'(b.out_valid), 1);
    chk("add_data", 32'(b.out_data), 12);
    chk("add_op", 32'(b.out_op), 1);
    chk("add_flag", 32'(b.out_flag), 0);
    chk("add_level", 32'(b.level), 1);

    // Sub result 3-5, popping the previous head meanwhile
    cyc(1, 0, '0, 1);
    cyc(0, 0, 5'b11110, 0);
    cyc(0, 0, '0, 0);
    @(negedge clk);
    chk("sub_data", 32'(b.out_data), 30);
    chk("sub_op", 32'(b.out_op), 0);
    chk("sub_flag", 32'(b.out_flag), 1);
    chk("sub_level", 32'(b.level), 1);
    cyc(0, 0, '0, 1);
    cyc(0, 0, '0, 0);
    cyc(0, 0, '0, 0);

    // Six results into a four-entry FIFO
    for (int k = 0; k < 6; k++) cyc(1, 1'($urandom_range(0, 1)), DW'(k), 0);
    cyc(0, 0, 5'd6, 0);
    cyc(0, 0, '0, 0);
    @(negedge clk);
    chk("ovf_full", 32'(b.full), 1);
    chk("ovf_level", 32'(b.level), 4);
    chk("ovf_drop", 32'(b.drop_cnt), 2);
    cyc(0, 0, '0, 1);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("ovf_order", 32'(b.out_data), 32'(k));
    end
    cyc(0, 0, '0, 0);

    // Streaming through a full FIFO across pointer wrap
    for (int k = 0; k < 4; k++) cyc(1, 1'($urandom_range(0, 1)), rnd_d(), 0);
    cyc(0, 0, rnd_d(), 0);
    cyc(1, 1'($urandom_range(0, 1)), rnd_d(), 0);
    for (int k = 0; k < 20; k++) begin
      cyc(1, 1'($urandom_range(0, 1)), rnd_d(), 1);
      @(negedge clk);
      chk("wrap_level", 32'(b.level), 4);
    end
    chk("wrap_drop", 32'(b.drop_cnt), 2);
    cyc(0, 0, rnd_d(), 1);
    repeat (6) cyc(0, 0, '0, 1);

    // Random traffic
    for (int k = 0; k < 400; k++)
      cyc(1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 1)), rnd_d(),
          1'($urandom_range(0, 99) < 50));
    repeat (8) cyc(0, 0, rnd_d(), 1);

    // Reset the cycle after an enable
    cyc(1, 1, '0, 0);
    @(posedge clk); #1;
    rst_n = 1'b0; b.in_en = 1'b0; b.in_data = 5'd9;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) cyc(0, 0, '0, 0);
    @(negedge clk);
    chk("mid_rst_empty", 32'(b.empty), 1);
    chk("mid_rst_valid", 32'(b.out_valid), 0);
    chk("mid_rst_drop", 32'(b.drop_cnt), 0);

    // Drop counter saturation
    for (int k = 0; k < 310; k++) cyc(1, 1'($urandom_range(0, 1)), rnd_d(), 0);
    @(negedge clk);
    chk("sat_drop", 32'(b.drop_cnt), 255);
    repeat (5) cyc(1, 0, rnd_d(), 0);
    @(negedge clk);
    chk("sat_hold", 32'(b.drop_cnt), 255);
    chk("sat_level", 32'(b.level), 4);

    cyc(0, 0, '0, 0);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
